// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MEM-stage state encoding, datapath constants and
// the MEM/WB bubble control pattern.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic memtoreg;
    logic regwrite;
  } wb_ctrl_t;

  // Control bits loaded into MEM/WB while the stage is stalled.
  localparam wb_ctrl_t MEMWB_BUBBLE = '{memtoreg: 1'b0, regwrite: 1'b0};

  function automatic logic word_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble clears the write-back controls and holds the data
// fields; otherwise a load captures the next values.
module mem_wb_reg #(
  parameter int DATA_W = mips_pkg::DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            load,
  input  logic                            bubble,
  input  logic                            memtoreg_next,
  input  logic                            regwrite_next,
  input  logic [DATA_W-1:0]               readdata_next,
  input  logic [DATA_W-1:0]               result_next,
  input  logic [mips_pkg::REG_ADDR_W-1:0] r_next,
  output logic                            wb_memtoreg,
  output logic                            wb_regwrite,
  output logic [DATA_W-1:0]               wb_readdata,
  output logic [DATA_W-1:0]               wb_result,
  output logic [mips_pkg::REG_ADDR_W-1:0] wb_r
);
  import mips_pkg::*;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_memtoreg <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_readdata <= '0;
      wb_result   <= '0;
      wb_r        <= '0;
    end else if (bubble) begin
      wb_memtoreg <= MEMWB_BUBBLE.memtoreg;
      wb_regwrite <= MEMWB_BUBBLE.regwrite;
    end else if (load) begin
      wb_memtoreg <= memtoreg_next;
      wb_regwrite <= regwrite_next;
      wb_readdata <= readdata_next;
      wb_result   <= result_next;
      wb_r        <= r_next;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues loads/stores over a req/ack handshake, stalls upstream while
// an access is outstanding and feeds MEM/WB. Optional feature macro: MEM_ALIGN_CHECK_EN.
module mem_stage #(
  parameter int DATA_W      = mips_pkg::DATA_W,
  parameter int ADDR_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ex_memwrite,
  input  logic                            ex_memread,
  input  logic                            ex_memtoreg,
  input  logic                            ex_regwrite,
  input  logic [DATA_W-1:0]               ex_result,
  input  logic [DATA_W-1:0]               ex_data,
  input  logic [mips_pkg::REG_ADDR_W-1:0] ex_r,
  output logic                            dmem_req,
  output logic                            dmem_we,
  output logic [ADDR_W-1:0]               dmem_addr,
  output logic [DATA_W-1:0]               dmem_wdata,
  input  logic [DATA_W-1:0]               dmem_rdata,
  input  logic                            dmem_ack,
  output logic                            mem_stall,
  output logic                            wb_memtoreg,
  output logic                            wb_regwrite,
  output logic [DATA_W-1:0]               wb_readdata,
  output logic [DATA_W-1:0]               wb_result,
  output logic [mips_pkg::REG_ADDR_W-1:0] wb_r,
  output logic                            err_timeout
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                            misalign_err
`endif
);
  import mips_pkg::*;

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  mem_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] hold_reg;

  logic              memop;
  logic              misaligned;
  logic              regwrite_next;
  logic [DATA_W-1:0] readdata_next;

  assign memop = ex_memread | ex_memwrite;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned    = memop & word_misaligned(ex_result[1:0]);
  // misalign_err is high only in the DONE cycle of the offending instruction.
  assign regwrite_next = ex_regwrite & ~misalign_err;
`else
  assign misaligned    = 1'b0;
  assign regwrite_next = ex_regwrite;
`endif

  assign readdata_next = (state_reg == DONE) ? hold_reg : '0;

  always_comb begin
    mem_stall = 1'b0;
    if (state_reg == ACCESS)
      mem_stall = 1'b1;
    else if (state_reg == IDLE && memop)
      mem_stall = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      hold_reg    <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      err_timeout <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      misalign_err <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (misaligned) begin
            hold_reg  <= '0;
            state_reg <= DONE;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_err <= 1'b1;
`endif
          end else if (memop) begin
            // A write takes priority when both memread and memwrite are set.
            dmem_req   <= 1'b1;
            dmem_we    <= ex_memwrite;
            dmem_addr  <= ex_result[ADDR_W-1:0];
            dmem_wdata <= ex_data;
            cnt_reg    <= '0;
            hold_reg   <= '0;
            state_reg  <= ACCESS;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req  <= 1'b0;
            if (!dmem_we)
              hold_reg <= dmem_rdata;
            state_reg <= DONE;
          end else if (cnt_reg == CNT_LAST) begin
            dmem_req    <= 1'b0;
            err_timeout <= 1'b1;
            hold_reg    <= '0;
            state_reg   <= DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          dmem_req  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  mem_wb_reg #(
    .DATA_W (DATA_W)
  ) u_mem_wb_reg (
    .clk           (clk),
    .rst           (rst),
    .load          (~mem_stall),
    .bubble        (mem_stall),
    .memtoreg_next (ex_memtoreg),
    .regwrite_next (regwrite_next),
    .readdata_next (readdata_next),
    .result_next   (ex_result),
    .r_next        (ex_r),
    .wb_memtoreg   (wb_memtoreg),
    .wb_regwrite   (wb_regwrite),
    .wb_readdata   (wb_readdata),
    .wb_result     (wb_result),
    .wb_r          (wb_r)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-instruction model of stall length, request window
// and write-back record, compared every cycle, plus literal checks on the directed cases.
module tb_mem_stage;

  localparam int T = 8;

  logic        clk;
  logic        rst;
  logic        ex_memwrite, ex_memread, ex_memtoreg, ex_regwrite;
  logic [31:0] ex_result, ex_data;
  logic [4:0]  ex_r;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall;
  logic        wb_memtoreg, wb_regwrite;
  logic [31:0] wb_readdata, wb_result;
  logic [4:0]  wb_r;
  logic        err_timeout;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_err;
`endif

  mem_stage #(.DATA_W(32), .ADDR_W(32), .ACK_TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_memwrite (ex_memwrite),
    .ex_memread  (ex_memread),
    .ex_memtoreg (ex_memtoreg),
    .ex_regwrite (ex_regwrite),
    .ex_result   (ex_result),
    .ex_data     (ex_data),
    .ex_r        (ex_r),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_rdata  (dmem_rdata),
    .dmem_ack    (dmem_ack),
    .mem_stall   (mem_stall),
    .wb_memtoreg (wb_memtoreg),
    .wb_regwrite (wb_regwrite),
    .wb_readdata (wb_readdata),
    .wb_result   (wb_result),
    .wb_r        (wb_r),
    .err_timeout (err_timeout)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign_err(misalign_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rw;
    bit          mtr;
    logic [31:0] res;
    logic [31:0] rd;
    logic [4:0]  r;
    bit          chk_rd;
  } rec_t;

  typedef struct {
    bit          stall;
    bit          req;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          full_wb;
    rec_t        wb;
    bit          err;
    bit          mis;
  } cyc_t;

  cyc_t exp_q[$];
  rec_t last_rec;
  bit   err_sticky;
  int   checks, errors;
  int   stall_seen, req_seen;
  int   d_stall, d_req;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Single compare process: one expected-cycle record per negedge while the model is active.
  always @(negedge clk) begin : cmp
    cyc_t e;
    stall_seen += (mem_stall === 1'b1) ? 1 : 0;
    req_seen   += (dmem_req === 1'b1) ? 1 : 0;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("mem_stall", 32'(mem_stall), 32'(e.stall));
      chk("dmem_req", 32'(dmem_req), 32'(e.req));
      if (e.req) begin
        chk("dmem_we", 32'(dmem_we), 32'(e.we));
        chk("dmem_addr", dmem_addr, e.addr);
        chk("dmem_wdata", dmem_wdata, e.wdata);
      end
      chk("err_timeout", 32'(err_timeout), 32'(e.err));
      chk("wb_regwrite", 32'(wb_regwrite), 32'(e.full_wb ? e.wb.rw : 1'b0));
      chk("wb_memtoreg", 32'(wb_memtoreg), 32'(e.full_wb ? e.wb.mtr : 1'b0));
      chk("wb_result", wb_result, e.wb.res);
      chk("wb_r", 32'(wb_r), 32'(e.wb.r));
      if (e.wb.chk_rd)
        chk("wb_readdata", wb_readdata, e.wb.rd);
`ifdef MEM_ALIGN_CHECK_EN
      chk("misalign_err", 32'(misalign_err), 32'(e.mis));
`endif
    end
  end

  // ack_at: ACCESS cycle (1-based) carrying dmem_ack, 0 = never; stray: ack outside ACCESS.
  task automatic run_op(input bit rd, input bit wr, input bit mtr, input bit rw,
                        input logic [31:0] res, input logic [31:0] data, input logic [4:0] r,
                        input int ack_at, input logic [31:0] rdata, input bit stray);
    bit   memop, mis, acked;
    int   n_acc, total;
    cyc_t e;
    rec_t nrec;
    memop = rd | wr;
    mis   = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = memop && (res[1:0] != 2'b00);
`endif
    acked = memop && !mis && ack_at >= 1 && ack_at <= T;
    n_acc = (!memop || mis) ? 0 : (acked ? ack_at : T);
    total = !memop ? 1 : n_acc + 2;
    for (int c = 0; c < total; c++) begin
      @(posedge clk);
      #1;
      ex_memread  = rd;
      ex_memwrite = wr;
      ex_memtoreg = mtr;
      ex_regwrite = rw;
      ex_result   = res;
      ex_data     = data;
      ex_r        = r;
      if (c >= 1 && c <= n_acc) begin
        dmem_ack   = acked && (c == ack_at);
        dmem_rdata = (acked && c == ack_at) ? rdata : 32'hDEAD_BEEF;
      end else begin
        dmem_ack   = stray;
        dmem_rdata = ~rdata;
      end
      e.stall   = memop && (c < total - 1);
      e.req     = (c >= 1 && c <= n_acc);
      e.we      = wr;
      e.addr    = res;
      e.wdata   = data;
      e.full_wb = (c == 0);
      e.wb      = last_rec;
      e.err     = err_sticky || (memop && !mis && !acked && c == total - 1);
      e.mis     = mis && (c == total - 1);
      exp_q.push_back(e);
    end
    if (memop && !mis && !acked)
      err_sticky = 1'b1;
    nrec.rw     = rw && !mis;
    nrec.mtr    = mtr;
    nrec.res    = res;
    nrec.r      = r;
    nrec.chk_rd = !memop || (rd && !wr && !mis);
    nrec.rd     = (rd && !wr && acked) ? rdata : 32'h0;
    last_rec    = nrec;
  endtask

  task automatic op(input bit rd, input bit wr, input bit mtr, input bit rw,
                    input logic [31:0] res, input logic [31:0] data, input logic [4:0] r,
                    input int ack_at, input logic [31:0] rdata, input bit stray);
    int s0, q0;
    s0 = stall_seen;
    q0 = req_seen;
    run_op(rd, wr, mtr, rw, res, data, r, ack_at, rdata, stray);
    @(negedge clk);
    #1;
    d_stall = stall_seen - s0;
    d_req   = req_seen - q0;
    $display("op rd=%0b wr=%0b res=%h r=%0d ack_at=%0d: stall=%0d req=%0d", rd, wr, res, r,
             ack_at, d_stall, d_req);
  endtask

  task automatic nop();
    op(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 32'h0, 0);
  endtask

  task automatic clear_model();
    last_rec = '{rw: 0, mtr: 0, res: 32'h0, rd: 32'h0, r: 5'd0, chk_rd: 1};
    err_sticky = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dmem_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_dmem_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_dmem_addr"}, dmem_addr, 32'd0);
    chk({tag, "_dmem_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_wb_regwrite"}, 32'(wb_regwrite), 32'd0);
    chk({tag, "_wb_memtoreg"}, 32'(wb_memtoreg), 32'd0);
    chk({tag, "_wb_readdata"}, wb_readdata, 32'd0);
    chk({tag, "_wb_result"}, wb_result, 32'd0);
    chk({tag, "_wb_r"}, 32'(wb_r), 32'd0);
    chk({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    checks = 0; errors = 0; stall_seen = 0; req_seen = 0;
    rst = 1'b0;
    ex_memwrite = 0; ex_memread = 0; ex_memtoreg = 0; ex_regwrite = 0;
    ex_result = 0; ex_data = 0; ex_r = 0; dmem_rdata = 0; dmem_ack = 0;
    clear_model();

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    chk("reset_mem_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;

    // ALU op: one-edge latency, never stalls.
    op(0, 0, 0, 1, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0, 0);
    chk("alu_stall_cycles", 32'(d_stall), 32'd0);
    nop();
    chk("alu_wb_result", wb_result, 32'h0000_1234);
    chk("alu_wb_r", 32'(wb_r), 32'd5);
    chk("alu_wb_regwrite", 32'(wb_regwrite), 32'd1);

    // Load, ack in 4th ACCESS cycle, stray acks outside ACCESS.
    op(1, 0, 1, 1, 32'h0000_0040, 32'h0, 5'd7, 4, 32'hCAFE_F00D, 1);
    chk("load_stall_cycles", 32'(d_stall), 32'd5);
    nop();
    chk("load_wb_readdata", wb_readdata, 32'hCAFE_F00D);
    chk("load_wb_memtoreg", 32'(wb_memtoreg), 32'd1);

    // Store acked in first ACCESS cycle: 3-cycle latency.
    op(0, 1, 0, 0, 32'h0000_0044, 32'hA5A5_A5A5, 5'd0, 1, 32'h0, 0);
    chk("store_stall_cycles", 32'(d_stall), 32'd2);
    chk("store_req_cycles", 32'(d_req), 32'd1);

    // Read+write together: write wins; then back-to-back ALU and load.
    op(1, 1, 0, 0, 32'h0000_0048, 32'h1122_3344, 5'd0, 2, 32'h0000_0055, 0);
    op(0, 0, 0, 1, 32'hFFFF_0000, 32'h0, 5'd31, 0, 32'h0, 0);
    op(1, 0, 1, 1, 32'h0000_004C, 32'h0, 5'd12, 3, 32'h1357_9BDF, 0);

    // Timeout: never acked.
    op(1, 0, 1, 1, 32'h0000_0050, 32'h0, 5'd9, 0, 32'h0000_0099, 0);
    chk("timeout_req_cycles", 32'(d_req), 32'd8);
    chk("timeout_stall_cycles", 32'(d_stall), 32'd9);
    nop();
    chk("timeout_err", 32'(err_timeout), 32'd1);
    chk("timeout_wb_readdata", wb_readdata, 32'd0);
    op(0, 0, 0, 1, 32'h0000_0777, 32'h0, 5'd3, 0, 32'h0, 0);
    op(1, 0, 1, 1, 32'h0000_0060, 32'h0, 5'd4, 2, 32'h2468_ACE0, 0);
    nop();
    chk("resume_wb_readdata", wb_readdata, 32'h2468_ACE0);

`ifdef MEM_ALIGN_CHECK_EN
    op(1, 0, 1, 1, 32'h0000_0042, 32'h0, 5'd6, 1, 32'h0BAD_0BAD, 0);
    chk("misalign_req_cycles", 32'(d_req), 32'd0);
    nop();
    chk("misalign_wb_regwrite", 32'(wb_regwrite), 32'd0);
`endif

    // Reset in the middle of an access.
    @(posedge clk);
    #1;
    ex_memread = 1; ex_memwrite = 0; ex_regwrite = 1; ex_memtoreg = 1;
    ex_result = 32'h0000_0080; ex_r = 5'd3; dmem_ack = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst_req_before", 32'(dmem_req), 32'd1);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    ex_memread = 0; ex_regwrite = 0; ex_memtoreg = 0; ex_result = 0; ex_r = 0;
    #1;
    chk("midrst_mem_stall", 32'(mem_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_req_held", 32'(dmem_req), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    clear_model();

    op(0, 0, 0, 1, 32'h0000_0ABC, 32'h0, 5'd10, 0, 32'h0, 0);
    chk("postrst_stall_cycles", 32'(d_stall), 32'd0);
    op(0, 1, 0, 0, 32'h0000_0090, 32'h0F0F_0F0F, 5'd0, 1, 32'h0, 0);
    nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
